// File: rtl/sram_resp_if.sv
// Address/control side of the SRAM bus, plus the read-valid indication back to the host.
interface sram_resp_if;
  logic [14:0] sram_addr_r;
  logic        sram_cs;
  logic        sram_oe;
  logic        sram_we;
  logic        rd_data_vld;

  modport master (
    output sram_addr_r, sram_cs, sram_oe, sram_we,
    input  rd_data_vld
  );

  modport slave (
    input  sram_addr_r, sram_cs, sram_oe, sram_we,
    output rd_data_vld
  );
endinterface

// File: rtl/sram_resp.sv
// SRAM responder: 32K x 8 storage, RD_LAT-deep read pipeline driving a shared
// tristate data bus, per-block write map, saturating byte counters, protocol-error flag.
module sram_resp #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  sram_resp_if.slave       bus,
  inout  wire  [7:0]       sram_data,
  input  logic             blk_clr,
  input  logic [8:0]       blk_clr_idx,
  input  logic             cnt_clr,
  output logic [511:0]     blk_wr_map,
  output logic [CNT_W-1:0] wr_byte_cnt,
  output logic [CNT_W-1:0] rd_byte_cnt,
  output logic             proto_err
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [7:0] mem [32768];
  logic       is_wr, is_rd, is_err;
  logic [7:0] data_p0;
  logic       vld_p0;
  logic [7:0] out_data;
  logic       out_vld;

  assign is_wr  = !bus.sram_cs &&  bus.sram_oe && !bus.sram_we;
  assign is_rd  = !bus.sram_cs && !bus.sram_oe &&  bus.sram_we;
  assign is_err = !bus.sram_cs && !bus.sram_oe && !bus.sram_we;

  // Stage p0: storage access; memory and data registers carry no reset
  always_ff @(posedge sys_clk) begin
    if (is_wr) mem[bus.sram_addr_r] <= sram_data;
    if (is_rd) data_p0 <= mem[bus.sram_addr_r];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_p0      <= 1'b0;
      blk_wr_map  <= '0;
      wr_byte_cnt <= '0;
      rd_byte_cnt <= '0;
      proto_err   <= 1'b0;
    end else begin
      vld_p0 <= is_rd;
      // a set later in this block overrides a same-edge clear of the same bit
      if (blk_clr) blk_wr_map[blk_clr_idx] <= 1'b0;
      if (is_wr)   blk_wr_map[bus.sram_addr_r[14:6]] <= 1'b1;
      if (cnt_clr) begin
        wr_byte_cnt <= '0;
        rd_byte_cnt <= '0;
        proto_err   <= 1'b0;
      end else begin
        if (is_wr) wr_byte_cnt <= sat_inc(wr_byte_cnt);
        if (is_rd) rd_byte_cnt <= sat_inc(rd_byte_cnt);
        if (is_err || (is_wr && out_vld)) proto_err <= 1'b1;
      end
    end
  end

  // Stage p1: optional second pipeline register for RD_LAT=2
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [7:0] data_p1;
      logic       vld_p1;

      always_ff @(posedge sys_clk) data_p1 <= data_p0;

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) vld_p1 <= 1'b0;
        else         vld_p1 <= vld_p0;
      end

      assign out_data = data_p1;
      assign out_vld  = vld_p1;
    end else begin : g_lat1
      assign out_data = data_p0;
      assign out_vld  = vld_p0;
    end
  endgenerate

  // Drive enable is purely the registered valid bit
  assign sram_data       = out_vld ? out_data : 8'bz;
  assign bus.rd_data_vld = out_vld;

endmodule

// File: tb/tb_sram_resp.sv
// Scoreboard bench: two instances (RD_LAT=1/CNT_W=4 and RD_LAT=2/CNT_W=16) see identical stimulus.
module tb_sram_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1, oe = 1'b1, we = 1'b1;
  logic [14:0] addr = '0;
  logic [7:0]  tb_dat = '0;
  logic        tb_drv = 1'b0;
  logic        blk_clr = 1'b0;
  logic [8:0]  blk_clr_idx = '0;
  logic        cnt_clr = 1'b0;

  wire  [7:0]   d1, d2;
  logic [511:0] map1, map2;
  logic [3:0]   wc1, rc1;
  logic [15:0]  wc2, rc2;
  logic         perr1, perr2;

  int checks = 0;
  int failures = 0;
  logic [7:0] mem_m [int];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  sram_resp_if b1 ();
  sram_resp_if b2 ();
  assign b1.sram_addr_r = addr;
  assign b1.sram_cs = cs;
  assign b1.sram_oe = oe;
  assign b1.sram_we = we;
  assign b2.sram_addr_r = addr;
  assign b2.sram_cs = cs;
  assign b2.sram_oe = oe;
  assign b2.sram_we = we;
  assign d1 = tb_drv ? tb_dat : 8'bz;
  assign d2 = tb_drv ? tb_dat : 8'bz;

  sram_resp #(.RD_LAT(1), .CNT_W(4)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .bus(b1.slave), .sram_data(d1),
    .blk_clr(blk_clr), .blk_clr_idx(blk_clr_idx), .cnt_clr(cnt_clr),
    .blk_wr_map(map1), .wr_byte_cnt(wc1), .rd_byte_cnt(rc1), .proto_err(perr1)
  );

  sram_resp #(.RD_LAT(2), .CNT_W(16)) dut2 (
    .sys_clk(clk), .sys_rst(rst), .bus(b2.slave), .sram_data(d2),
    .blk_clr(blk_clr), .blk_clr_idx(blk_clr_idx), .cnt_clr(cnt_clr),
    .blk_wr_map(map2), .wr_byte_cnt(wc2), .rd_byte_cnt(rc2), .proto_err(perr2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic op(input logic c, input logic o, input logic w, input logic [14:0] a,
                    input logic [7:0] d, input logic drv, input logic bc,
                    input logic [8:0] bi, input logic cc);
    @(posedge clk); #1;
    cs = c; oe = o; we = w; addr = a; tb_dat = d; tb_drv = drv;
    blk_clr = bc; blk_clr_idx = bi; cnt_clr = cc;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    op(1'b0, 1'b1, 1'b0, a, d, 1'b1, 1'b0, 9'd0, 1'b0);
    mem_m[int'(a)] = d;
  endtask

  task automatic rd(input logic [14:0] a);
    op(1'b0, 1'b0, 1'b1, a, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0);
    q1.push_back(mem_m[int'(a)]);
    q2.push_back(mem_m[int'(a)]);
  endtask

  task automatic idle();
    op(1'b1, 1'b1, 1'b1, 15'd0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0);
  endtask

  // Monitor: every valid output byte is matched against the queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (b1.rd_data_vld) begin
        if (q1.size() == 0) chk("rd_extra_lat1", 64'd1, 64'd0);
        else chk("rd_data_lat1", {56'd0, d1}, {56'd0, q1.pop_front()});
      end
      if (b2.rd_data_vld) begin
        if (q2.size() == 0) chk("rd_extra_lat2", 64'd1, 64'd0);
        else chk("rd_data_lat2", {56'd0, d2}, {56'd0, q2.pop_front()});
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_map1", {63'd0, map1 == '0}, 64'd1);
    chk("rst_map2", {63'd0, map2 == '0}, 64'd1);
    chk("rst_cnt1", {56'd0, wc1, rc1}, 64'd0);
    chk("rst_cnt2", {32'd0, wc2, rc2}, 64'd0);
    chk("rst_perr", {62'd0, perr1, perr2}, 64'd0);
    chk("rst_vld", {62'd0, b1.rd_data_vld, b2.rd_data_vld}, 64'd0);
    rst = 1'b0;

    // single write then read, with latency check
    wr(15'h0040, 8'hA5);
    rd(15'h0040);
    idle();
    chk("lat_e1_vld1", {63'd0, b1.rd_data_vld}, 64'd1);
    chk("lat_e1_vld2", {63'd0, b2.rd_data_vld}, 64'd0);
    idle();
    chk("lat_e2_vld1", {63'd0, b1.rd_data_vld}, 64'd0);
    chk("lat_e2_vld2", {63'd0, b2.rd_data_vld}, 64'd1);
    chk("map1_bit1", {63'd0, map1[1]}, 64'd1);
    chk("map2_bit1", {63'd0, map2[1]}, 64'd1);
    chk("cnt1_single", {56'd0, wc1, rc1}, 64'h11);
    chk("cnt2_single", {32'd0, wc2, rc2}, 64'h0001_0001);

    // block-map set wins over same-edge clear, later clear alone works
    op(1'b0, 1'b1, 1'b0, 15'h0080, 8'h5A, 1'b1, 1'b1, 9'd2, 1'b0);
    mem_m[32'h80] = 8'h5A;
    idle();
    chk("map_set_wins", {62'd0, map1[2], map2[2]}, 64'd3);
    op(1'b1, 1'b1, 1'b1, 15'd0, 8'h00, 1'b0, 1'b1, 9'd2, 1'b0);
    idle();
    chk("map_clr", {62'd0, map1[2], map2[2]}, 64'd0);
    chk("map_clr_keep", {62'd0, map1[1], map2[1]}, 64'd3);

    // 64-byte burst at top block, counters saturate on the narrow instance
    op(1'b1, 1'b1, 1'b1, 15'd0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b1);
    for (int i = 0; i < 64; i++) wr(15'h7FC0 + 15'(i), 8'(i));
    for (int i = 0; i < 64; i++) rd(15'h7FC0 + 15'(i));
    repeat (3) idle();
    chk("map_bit511", {62'd0, map1[511], map2[511]}, 64'd3);
    chk("cnt1_sat", {56'd0, wc1, rc1}, 64'hFF);
    chk("cnt2_burst", {32'd0, wc2, rc2}, {32'd0, 16'd64, 16'd64});

    // 20 writes after clear, then clear coinciding with a write
    op(1'b1, 1'b1, 1'b1, 15'd0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b1);
    for (int i = 0; i < 20; i++) wr(15'h0100 + 15'(i), 8'(i + 8'h30));
    idle();
    chk("wc1_20", {60'd0, wc1}, 64'd15);
    chk("wc2_20", {48'd0, wc2}, 64'd20);
    op(1'b0, 1'b1, 1'b0, 15'h0120, 8'h77, 1'b1, 1'b0, 9'd0, 1'b1);
    mem_m[32'h120] = 8'h77;
    idle();
    chk("wc_clr_wins", {44'd0, wc1, wc2}, 64'd0);

    // ERR edge: no write, sticky flag, cleared by cnt_clr
    op(1'b0, 1'b0, 1'b0, 15'h0040, 8'hFF, 1'b1, 1'b0, 9'd0, 1'b0);
    repeat (3) idle();
    chk("perr_sticky", {62'd0, perr1, perr2}, 64'd3);
    chk("err_no_cnt", {12'd0, wc1, rc1, wc2, rc2}, 64'd0);
    rd(15'h0040);
    idle();
    op(1'b0, 1'b0, 1'b0, 15'h0040, 8'h00, 1'b0, 1'b0, 9'd0, 1'b1);
    repeat (2) idle();
    chk("perr_clr_wins", {62'd0, perr1, perr2}, 64'd0);
    chk("cnt_clr_rd", {44'd0, rc1, rc2}, 64'd0);

    // write while the 1-cycle instance drives the bus
    rd(15'h0040);
    op(1'b0, 1'b1, 1'b0, 15'h0041, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0);
    repeat (2) idle();
    chk("contention_lat1", {63'd0, perr1}, 64'd1);
    chk("contention_lat2", {63'd0, perr2}, 64'd0);
    op(1'b1, 1'b1, 1'b1, 15'd0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b1);

    // reset in the middle of a burst read
    rd(15'h7FC0);
    rd(15'h7FC1);
    rd(15'h7FC2);
    #2;
    rst = 1'b1;
    cs = 1'b1; oe = 1'b1; we = 1'b1;
    #1;
    chk("rst_mid_vld", {62'd0, b1.rd_data_vld, b2.rd_data_vld}, 64'd0);
    q1.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_rst_vld", {62'd0, b1.rd_data_vld, b2.rd_data_vld}, 64'd0);
    end
    chk("post_rst_map", {62'd0, map1 == '0, map2 == '0}, 64'd3);
    chk("post_rst_cnt", {12'd0, wc1, rc1, wc2, rc2}, 64'd0);
    rd(15'h0040);
    rd(15'h7FC5);
    repeat (4) idle();
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_resp.md
SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 The block SHALL have one clock and one reset: clock sys_clk, reset sys_rst, asynchronous and active-high.
REQ-002 Parameter RD_LAT, default 1, SHALL set the read latency in cycles; legal values are 1 and 2.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the byte counters.
REQ-004 Ports (name  direction  width  meaning):
- sys_clk  in  1  clock, rising edge.
- sys_rst  in  1  asynchronous reset, active-high.
- sram_addr_r  in  15  byte address.
- sram_data  inout  8  bidirectional data bus.
- sram_cs  in  1  chip select, active-low.
- sram_oe  in  1  output enable, active-low.
- sram_we  in  1  write enable, active-low.
- blk_clr  in  1  clear one block-map bit.
- blk_clr_idx  in  9  index of the block-map bit to clear.
- cnt_clr  in  1  clear both counters and proto_err.
- blk_wr_map  out  512  per-64-byte-block written flag; bit i covers addr[14:6]==i.
- wr_byte_cnt  out  CNT_W  accepted write count, saturating.
- rd_byte_cnt  out  CNT_W  accepted read count, saturating.
- rd_data_vld  out  1  high while this block drives sram_data.
- proto_err  out  1  sticky protocol-error flag.

Function
REQ-005 Storage SHALL be a 32768 x 8 array; its contents SHALL NOT be reset and are undefined until written.
REQ-006 Cycle classification SHALL be made at each rising edge from (cs,oe,we):
- WRITE = (0,1,0)
- READ = (0,0,1)
- ERR = (0,0,0)
- all other combinations = IDLE.
REQ-007 On a WRITE edge, mem[sram_addr_r] SHALL take sram_data, and blk_wr_map[sram_addr_r[14:6]] SHALL be set.
REQ-008 On a READ edge, the block SHALL capture mem[sram_addr_r] into a read pipeline of depth RD_LAT, tagged valid.
REQ-009 After RD_LAT edges, the pipeline SHALL drive the data onto sram_data with rd_data_vld=1 for exactly one cycle per READ.
REQ-010 Back-to-back READs SHALL yield one byte per cycle in address order.
REQ-011 When no valid pipeline output exists, sram_data SHALL be high-Z and rd_data_vld SHALL be 0.
REQ-012 The drive enable SHALL come from a register only; it SHALL NOT be gated combinationally by the bus inputs.
REQ-013 ERR edges SHALL neither write nor read, and SHALL set proto_err.
REQ-014 proto_err SHALL also be set on any WRITE edge while rd_data_vld=1 (bus contention); the write SHALL still occur.
REQ-015 wr_byte_cnt SHALL increment by 1 on each WRITE edge and rd_byte_cnt by 1 on each READ edge.
REQ-016 Both counters SHALL saturate at 2^CNT_W-1 with no wrap-around.
REQ-017 cnt_clr SHALL zero both counters and proto_err on the next edge.
REQ-018 If cnt_clr coincides with an increment, clear SHALL win and the counter SHALL read 0; if it coincides with an error, proto_err SHALL be 0.
REQ-019 blk_clr SHALL clear blk_wr_map[blk_clr_idx] on the next edge; if it coincides with a WRITE to the same block, set SHALL win.
REQ-020 A WRITE and a READ SHALL never occur on the same edge; a READ issued the edge after a WRITE to the same address SHALL return the new data.
REQ-021 The read pipeline SHALL use the address sampled at the READ edge; address changes afterwards SHALL NOT affect the returned byte.

Reset
REQ-022 While sys_rst=1, asynchronously:
- blk_wr_map=0, wr_byte_cnt=0, rd_byte_cnt=0, proto_err=0
- pipeline valid bits=0, rd_data_vld=0, sram_data=Z.
REQ-023 A read in flight when reset asserts SHALL be discarded and no data SHALL be driven after reset is released.
REQ-024 Memory contents SHALL survive reset.

Verification
REQ-025 Scenario: write 0xA5 at addr 0x0040, then READ 0x0040 with RD_LAT=1 -> next cycle sram_data=0xA5, rd_data_vld=1; blk_wr_map[1]=1; wr_byte_cnt=1, rd_byte_cnt=1.
REQ-026 Scenario: burst-write 64 bytes (value=i) at 0x7FC0..0x7FFF, then burst-read them with RD_LAT=2 -> bytes 0..63 in order, first byte 2 cycles after the first READ edge; blk_wr_map[511]=1.
REQ-027 Scenario: assert cs=oe=we=0 for one edge -> no memory change, proto_err=1 and held; then cnt_clr -> proto_err=0, counters=0.
REQ-028 Scenario: CNT_W=4, 20 WRITEs -> wr_byte_cnt=15; cnt_clr on the same edge as a WRITE -> 0.
REQ-029 Scenario: WRITE to addr 0x0080 with blk_clr=1, blk_clr_idx=2 on the same edge -> blk_wr_map[2]=1; blk_clr alone on a later edge -> 0.
REQ-030 Scenario: assert sys_rst mid-burst read -> sram_data=Z and rd_data_vld=0 immediately; after release, a READ of a previously written address returns the pre-reset data.
